// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: request op encodings, FSM states
// and small op-classification helpers.
package lsu_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_PUSH  = 2'b10,
    OP_POP   = 2'b11
  } lsu_op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_RESP   = 2'b10
  } lsu_state_e;

  function automatic logic op_writes(lsu_op_e op);
    return (op == OP_STORE) || (op == OP_PUSH);
  endfunction

  function automatic logic op_reads(lsu_op_e op);
    return (op == OP_LOAD) || (op == OP_POP);
  endfunction

endpackage

// File: rtl/lsu_stack_ptr.sv
// Stack pointer register with full/empty detection. The stack grows downward
// from SP_INIT; a push may write no lower than STACK_LIMIT.
module lsu_stack_ptr #(
  parameter logic [7:0] SP_INIT     = 8'hFF,
  parameter logic [7:0] STACK_LIMIT = 8'hC0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push_i,
  input  logic       pop_i,
  output logic [7:0] sp_o,
  output logic [7:0] sp_plus1_o,
  output logic       full_o,
  output logic       empty_o
);

  logic [7:0] sp_q;
  logic [7:0] sp_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    sp_d = sp_q;
    if (push_i)     sp_d = sp_q - 8'd1;
    else if (pop_i) sp_d = sp_q + 8'd1;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sp_q <= SP_INIT;
    else       sp_q <= sp_d;
  end

  assign sp_o       = sp_q;
  assign sp_plus1_o = sp_q + 8'd1;
  assign full_o     = (sp_q < STACK_LIMIT);
  assign empty_o    = (sp_q == SP_INIT);

endmodule

// File: rtl/load_store_unit.sv
// Three-state load/store unit: one request per IDLE->ACCESS->RESP pass, with
// base+offset addressing for LOAD/STORE and a downward-growing stack for PUSH/POP.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter logic [7:0] SP_INIT     = 8'hFF,
  parameter logic [7:0] STACK_LIMIT = 8'hC0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [7:0] req_base,
  input  logic [7:0] req_offset,
  input  logic [7:0] req_wdata,
  output logic       mem_Rm,
  output logic       mem_Wm,
  output logic [7:0] mem_address,
  output logic [7:0] mem_RegVal,
  input  logic [7:0] mem_Data_out,
  output logic       rsp_valid,
  output logic       rsp_err,
  output logic [7:0] rsp_data,
  output logic [7:0] sp,
  output logic       stack_err
);

  lsu_state_e state_q, state_d;
  lsu_op_e    op_q;
  lsu_op_e    req_op_e;
  logic       reject_q, reject_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q;
  logic [7:0] rdata_q;
  logic       stack_err_q;
  logic       accept;
  logic       push_en, pop_en;
  logic [7:0] sp_cur, sp_plus1;
  logic       stack_full, stack_empty;

  assign req_op_e = lsu_op_e'(req_op);

  lsu_stack_ptr #(
    .SP_INIT     (SP_INIT),
    .STACK_LIMIT (STACK_LIMIT)
  ) u_stack_ptr (
    .clock      (clock),
    .reset      (reset),
    .push_i     (push_en),
    .pop_i      (pop_en),
    .sp_o       (sp_cur),
    .sp_plus1_o (sp_plus1),
    .full_o     (stack_full),
    .empty_o    (stack_empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Strobes and response flags decode straight from the state register, so an
  // asynchronous reset clears them in the same instant it clears the state.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    req_ready = 1'b0;
    mem_Rm    = 1'b0;
    mem_Wm    = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    push_en   = 1'b0;
    pop_en    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        mem_Rm  = !reject_q && op_reads(op_q);
        mem_Wm  = !reject_q && op_writes(op_q);
        push_en = !reject_q && (op_q == OP_PUSH);
        pop_en  = !reject_q && (op_q == OP_POP);
        state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = reject_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    reject_d = 1'b0;
    addr_d   = req_base + req_offset;
    unique case (req_op_e)
      OP_PUSH: begin
        addr_d   = sp_cur;
        reject_d = stack_full;
      end
      OP_POP: begin
        addr_d   = sp_plus1;
        reject_d = stack_empty;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q        <= OP_LOAD;
      reject_q    <= 1'b0;
      addr_q      <= 8'h00;
      wdata_q     <= 8'h00;
      rdata_q     <= 8'h00;
      stack_err_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q     <= req_op_e;
        reject_q <= reject_d;
        addr_q   <= addr_d;
        if (op_writes(req_op_e)) wdata_q <= req_wdata;
      end
      if (state_q == S_ACCESS) begin
        if (!reject_q && op_reads(op_q)) rdata_q <= mem_Data_out;
        if (reject_q) stack_err_q <= 1'b1;
      end
    end
  end

  assign mem_address = addr_q;
  assign mem_RegVal  = wdata_q;
  assign rsp_data    = rdata_q;
  assign sp          = sp_cur;
  assign stack_err   = stack_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random ops
// compared against an array/arithmetic model of the memory and stack.
module tb_load_store_unit;

  localparam logic [7:0] SP_INIT     = 8'hFF;
  localparam logic [7:0] STACK_LIMIT = 8'hC0;

  logic       clock = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_base, req_offset, req_wdata;
  logic       mem_Rm, mem_Wm;
  logic [7:0] mem_address, mem_RegVal, mem_Data_out;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_data;
  logic [7:0] sp;
  logic       stack_err;

  int n_checks = 0;
  int n_errors = 0;

  // Data memory: combinational read, falling-edge write.
  logic [7:0] mem [256];
  assign mem_Data_out = mem[mem_address];
  always @(negedge clock) if (mem_Wm) mem[mem_address] <= mem_RegVal;

  // Reference model state.
  logic [7:0] ref_mem [256];
  logic [7:0] exp_sp;
  logic       exp_stack_err;
  logic [7:0] exp_rdata;

  always #5 clock = ~clock;

  load_store_unit #(
    .SP_INIT     (SP_INIT),
    .STACK_LIMIT (STACK_LIMIT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_base     (req_base),
    .req_offset   (req_offset),
    .req_wdata    (req_wdata),
    .mem_Rm       (mem_Rm),
    .mem_Wm       (mem_Wm),
    .mem_address  (mem_address),
    .mem_RegVal   (mem_RegVal),
    .mem_Data_out (mem_Data_out),
    .rsp_valid    (rsp_valid),
    .rsp_err      (rsp_err),
    .rsp_data     (rsp_data),
    .sp           (sp),
    .stack_err    (stack_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_sp        = SP_INIT;
    exp_stack_err = 1'b0;
    exp_rdata     = 8'h00;
  endtask

  // One complete request: acceptance, ACCESS, RESP and return to IDLE.
  task automatic do_op(input logic [1:0] op, input logic [7:0] base,
                       input logic [7:0] off, input logic [7:0] wdata);
    logic       rej, rd, wr;
    logic [7:0] addr;
    int         guard;
    guard = 0;
    while (!req_ready && guard < 10) begin
      @(negedge clock);
      guard++;
    end
    check("ready_before_req", req_ready, 1);

    rej  = (op == 2'b10 && exp_sp < STACK_LIMIT) || (op == 2'b11 && exp_sp == SP_INIT);
    addr = (op == 2'b10) ? exp_sp : (op == 2'b11) ? exp_sp + 8'd1 : 8'((int'(base) + int'(off)) % 256);
    rd   = !rej && (op == 2'b00 || op == 2'b11);
    wr   = !rej && (op == 2'b01 || op == 2'b10);

    req_valid  = 1'b1;
    req_op     = op;
    req_base   = base;
    req_offset = off;
    req_wdata  = wdata;
    @(posedge clock);
    #1;
    // Garbage requests while busy must be ignored.
    req_op     = 2'($urandom_range(0, 3));
    req_base   = 8'($urandom);
    req_offset = 8'($urandom);
    req_wdata  = 8'($urandom);

    @(negedge clock);
    check("acc_Rm", mem_Rm, rd);
    check("acc_Wm", mem_Wm, wr);
    check("acc_ready", req_ready, 0);
    check("acc_rsp_valid", rsp_valid, 0);
    if (rd || wr) check("acc_addr", mem_address, addr);
    if (wr) check("acc_wdata", mem_RegVal, wdata);

    if (rej) exp_stack_err = 1'b1;
    else if (op == 2'b00) exp_rdata = ref_mem[addr];
    else if (op == 2'b01) ref_mem[addr] = wdata;
    else if (op == 2'b10) begin ref_mem[addr] = wdata; exp_sp = exp_sp - 8'd1; end
    else begin exp_rdata = ref_mem[addr]; exp_sp = exp_sp + 8'd1; end

    @(negedge clock);
    check("resp_valid", rsp_valid, 1);
    check("resp_err", rsp_err, rej);
    check("resp_data", rsp_data, exp_rdata);
    check("resp_sp", sp, exp_sp);
    check("resp_stack_err", stack_err, exp_stack_err);
    check("resp_strobes", {mem_Rm, mem_Wm}, 0);
    if (rd || wr) check("resp_addr_hold", mem_address, addr);
    req_valid = 1'b0;

    @(negedge clock);
    check("idle_rsp_valid", rsp_valid, 0);
    check("idle_ready", req_ready, 1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'h00;
      ref_mem[i] = 8'h00;
    end
    model_reset();
    reset = 1'b1; req_valid = 1'b0; req_op = 2'b00;
    req_base = 8'h00; req_offset = 8'h00; req_wdata = 8'h00;
    repeat (3) @(negedge clock);
    check("rst_outputs", {mem_Rm, mem_Wm, rsp_valid, rsp_err, stack_err}, 0);
    check("rst_sp", sp, SP_INIT);
    check("rst_addr", mem_address, 8'h00);
    check("rst_regval", mem_RegVal, 8'h00);
    check("rst_rdata", rsp_data, 8'h00);
    reset = 1'b0;
    #1 check("rst_ready_first", req_ready, 1);

    // POP on an empty stack is rejected and the fault is sticky.
    do_op(2'b11, 8'h00, 8'h00, 8'h00);
    check("empty_pop_sticky", stack_err, 1);

    // STORE then LOAD at base+offset, and a wrapping LOAD address.
    do_op(2'b01, 8'h10, 8'h05, 8'hA5);
    check("store_mem_15", mem[8'h15], 8'hA5);
    do_op(2'b00, 8'h10, 8'h05, 8'h00);
    do_op(2'b00, 8'hF0, 8'h20, 8'h00);

    // PUSH 11, PUSH 22, POP, POP.
    do_op(2'b10, 8'h00, 8'h00, 8'h11);
    do_op(2'b10, 8'h00, 8'h00, 8'h22);
    check("push_mem_ff", mem[8'hFF], 8'h11);
    check("push_mem_fe", mem[8'hFE], 8'h22);
    do_op(2'b11, 8'h00, 8'h00, 8'h00);
    check("pop1_data", rsp_data, 8'h22);
    do_op(2'b11, 8'h00, 8'h00, 8'h00);
    check("pop2_data", rsp_data, 8'h11);
    check("stack_err_still", stack_err, 1);

    // Reset during the ACCESS cycle of a PUSH aborts it.
    @(negedge clock);
    req_valid = 1'b1; req_op = 2'b10; req_wdata = 8'h5A;
    @(posedge clock);
    #1 check("abort_wm_before", mem_Wm, 1);
    reset = 1'b1;
    req_valid = 1'b0;
    #1;
    check("abort_strobes", {mem_Rm, mem_Wm}, 0);
    check("abort_sp", sp, SP_INIT);
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_stack_err", stack_err, 0);
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1 check("abort_ready", req_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("abort_no_rsp", rsp_valid, 0);
    end
    check("abort_no_write", mem[8'hFF], 8'h11);

    // Fill the stack down to BF, then one more PUSH is rejected.
    while (exp_sp >= STACK_LIMIT) do_op(2'b10, 8'h00, 8'h00, 8'($urandom));
    check("full_sp", sp, 8'hBF);
    do_op(2'b10, 8'h00, 8'h00, 8'hEE);
    check("full_sp_after", sp, 8'hBF);

    // Random mix checked against the model.
    for (int n = 0; n < 300; n++)
      do_op(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 8'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
